// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 8-entry register file with
// write-through read ports, and a retired-instruction counter.
module writeback_regfile #(
  parameter int DATA_W = 20,
  parameter int NREGS  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [2:0]        rs1_addr,
  input  logic [2:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              wb_we,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retired
);

  logic [3:0]        opcode;
  logic              is_ld;
  logic              is_alu;
  logic              is_bubble;
  logic [DATA_W-1:0] regs [NREGS];

  assign opcode    = instruction[19:16];
  assign wb_rd     = instruction[15:13];
  assign is_bubble = (instruction == '0);

  always_comb begin
    is_ld  = 1'b0;
    is_alu = 1'b0;
    unique case (1'b1)
      (opcode == 4'd1):                    is_ld  = 1'b1;
      (opcode >= 4'd3 && opcode <= 4'd9):  is_alu = 1'b1;
      default: ;
    endcase
  end

  assign wb_we   = (is_ld || is_alu) && (wb_rd != 3'd0);
  assign wb_data = is_ld ? mem_data : alu_result;

  // r0 is never written, so its storage stays at the reset value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (!is_bubble) begin
      retired <= retired + 1'b1;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    unique case (1'b1)
      (rs1_addr == 3'd0):              rs1_data = '0;
      (wb_we && rs1_addr == wb_rd):    rs1_data = wb_data;
      default: ;
    endcase
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    unique case (1'b1)
      (rs2_addr == 3'd0):              rs2_data = '0;
      (wb_we && rs2_addr == wb_rd):    rs2_data = wb_data;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with a reference model
// checked every cycle plus literal expectations.
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] instruction = '0;
  logic [19:0] alu_result = '0;
  logic [19:0] mem_data = '0;
  logic [2:0]  rs1_addr = '0;
  logic [2:0]  rs2_addr = '0;
  logic [19:0] rs1_data;
  logic [19:0] rs2_data;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [19:0] wb_data;
  logic [15:0] retired;

  int tests = 0;
  int fails = 0;

  int mreg [8];
  int mcnt;

  writeback_regfile dut (
    .clock(clock), .reset(reset),
    .instruction(instruction),
    .alu_result(alu_result), .mem_data(mem_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .retired(retired)
  );

  always #5 clock = ~clock;

  function automatic int m_op(input logic [19:0] ins);
    return int'(ins[19:16]);
  endfunction

  function automatic int m_rd(input logic [19:0] ins);
    return int'(ins[15:13]);
  endfunction

  function automatic bit m_we(input logic [19:0] ins);
    int op;
    op = m_op(ins);
    return (op == 1 || (op >= 3 && op <= 9)) && m_rd(ins) != 0;
  endfunction

  function automatic int m_wdata(input logic [19:0] ins,
                                 input logic [19:0] alu,
                                 input logic [19:0] mem);
    return (m_op(ins) == 1) ? int'(mem) : int'(alu);
  endfunction

  function automatic int m_read(input int a);
    if (a == 0) return 0;
    if (m_we(instruction) && a == m_rd(instruction))
      return m_wdata(instruction, alu_result, mem_data);
    return mreg[a];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mreg[i] <= 0;
      mcnt <= 0;
    end else begin
      if (m_we(instruction))
        mreg[m_rd(instruction)] <=
          m_wdata(instruction, alu_result, mem_data);
      if (instruction != 0) mcnt <= (mcnt + 1) % 65536;
    end
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("m_rs1", int'(rs1_data), m_read(int'(rs1_addr)));
      chk("m_rs2", int'(rs2_data), m_read(int'(rs2_addr)));
      chk("m_we", int'(wb_we), int'(m_we(instruction)));
      chk("m_rd", int'(wb_rd), m_rd(instruction));
      chk("m_wdata", int'(wb_data),
          m_wdata(instruction, alu_result, mem_data));
      chk("m_ret", int'(retired), mcnt);
    end
  end

  task automatic step(input logic [19:0] ins,
                      input logic [19:0] alu,
                      input logic [19:0] mem,
                      input logic [2:0] a1,
                      input logic [2:0] a2);
    @(posedge clock);
    #1;
    instruction = ins;
    alu_result  = alu;
    mem_data    = mem;
    rs1_addr    = a1;
    rs2_addr    = a2;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_ret", int'(retired), 0);
    chk("rst_rs1", int'(rs1_data), 0);

    step(20'h36000, 20'hABCDE, 20'h0, 3'd3, 3'd3);
    chk("byp_rs1", int'(rs1_data), 20'hABCDE);
    chk("byp_we", int'(wb_we), 1);
    step(20'h0, 20'h0, 20'h0, 3'd3, 3'd0);
    chk("st_rs1", int'(rs1_data), 20'hABCDE);
    chk("ret1", int'(retired), 1);

    step(20'h1A000, 20'h00010, 20'hFEDCB, 3'd0, 3'd0);
    chk("ld_wdata", int'(wb_data), 20'hFEDCB);
    step(20'h0, 20'h0, 20'h0, 3'd5, 3'd0);
    chk("ld_r5", int'(rs1_data), 20'hFEDCB);

    step(20'h30000, 20'hFFFFF, 20'h0, 3'd0, 3'd0);
    chk("r0_we", int'(wb_we), 0);
    chk("r0_rd", int'(rs1_data), 0);
    step(20'h0, 20'h0, 20'h0, 3'd0, 3'd0);
    chk("r0_ret", int'(retired), 3);

    step(20'h34000, 20'h00222, 20'h0, 3'd0, 3'd0);
    step(20'h24000, 20'h99999, 20'h0, 3'd2, 3'd0);
    chk("st_we", int'(wb_we), 0);
    chk("st_r2", int'(rs1_data), 20'h00222);
    step(20'h0, 20'h0, 20'h0, 3'd2, 3'd0);
    chk("st_ret", int'(retired), 5);
    step(20'h0, 20'h0, 20'h0, 3'd2, 3'd0);
    chk("nop_ret", int'(retired), 5);

    step(20'h3C000, 20'h00666, 20'h0, 3'd0, 3'd0);
    step(20'h3E000, 20'h00777, 20'h0, 3'd7, 3'd7);
    chk("dual_rs1", int'(rs1_data), 20'h00777);
    chk("dual_rs2", int'(rs2_data), 20'h00777);
    step(20'h3E000, 20'h00888, 20'h0, 3'd7, 3'd6);
    chk("mix_rs1", int'(rs1_data), 20'h00888);
    chk("mix_rs2", int'(rs2_data), 20'h00666);

    step(20'h36000, 20'h12345, 20'h0, 3'd3, 3'd0);
    step(20'h0, 20'h0, 20'h0, 3'd3, 3'd0);
    chk("pre_r3", int'(rs1_data), 20'h12345);
    chk("pre_ret", int'(retired), 9);
    #2 reset = 1'b0;
    #1;
    chk("arst_rs1", int'(rs1_data), 0);
    chk("arst_ret", int'(retired), 0);
    instruction = 20'h38000;
    alu_result  = 20'h44444;
    @(posedge clock);
    #1;
    instruction = 20'h0;
    rs1_addr    = 3'd4;
    #1;
    chk("held_r4", int'(rs1_data), 0);
    chk("held_ret", int'(retired), 0);
    #1 reset = 1'b1;

    step(20'h3E000, 20'h00777, 20'h0, 3'd7, 3'd0);
    step(20'h2E000, 20'h12121, 20'h0, 3'd7, 3'd4);
    repeat (65533) step(20'h2E000, 20'h12121, 20'h0, 3'd7, 3'd4);
    step(20'h2E000, 20'h12121, 20'h0, 3'd7, 3'd4);
    chk("pre_wrap", int'(retired), 16'hFFFF);
    step(20'h0, 20'h0, 20'h0, 3'd7, 3'd4);
    chk("wrap", int'(retired), 0);
    chk("wrap_r7", int'(rs1_data), 20'h00777);
    chk("wrap_r4", int'(rs2_data), 0);

    step(20'h0, 20'h0, 20'h0, 3'd0, 3'd0);
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Final pipeline stage, directly downstream of the MEM/WB pipeline register. It decodes the propagated 20-bit instruction and selects either the ALU result or the memory read data as the writeback value. It writes that value into an 8 x 20-bit register file and serves two combinational read ports to the decode stage, with same-cycle write-through bypass. It also counts retired instructions for debug and performance.

## Interface
Parameters:
- DATA_W, 20, datapath and register width
- NREGS, 8, number of architectural registers (address width 3)
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- instruction  in  20  instruction from MEM/WB (instructionPropagation)
- alu_result  in  20  ALU result from MEM/WB
- mem_data  in  20  memory read data from MEM/WB
- rs1_addr  in  3  read port 1 address (decode stage)
- rs2_addr  in  3  read port 2 address (decode stage)
- rs1_data  out  20  read port 1 data (combinational)
- rs2_data  out  20  read port 2 data (combinational)
- wb_we  out  1  writeback enable this cycle (combinational; for forwarding)
- wb_rd  out  3  writeback destination (combinational)
- wb_data  out  20  writeback value (combinational)
- retired  out  16  count of retired non-NOP instructions (registered)

## Operation
- Instruction fields: opcode = instruction[19:16]; rd = instruction[15:13].
- Opcode classes:
  - 0000 NOP: no write, not counted.
  - 0001 LD: write mem_data.
  - 0010 ST: no write, counted.
  - 0011-1001 ALU ops: write alu_result.
  - 1010-1111 (branch/jump/reserved): no write, counted.
- wb_we = write class AND rd != 0; wb_data = mem_data for LD, else alu_result; wb_rd = rd.
- When wb_we is low, wb_data still shows the mux output; consumers qualify it with wb_we.
- Register r0 always reads 0. Writes to r0 are suppressed (wb_we = 0).
- Registers r1-r7 are written on posedge clock when wb_we = 1.
- Read ports apply the rules below in this order:
  - addr == 0 -> 0.
  - else if wb_we and addr == wb_rd -> wb_data (bypass).
  - else -> stored register.
- Both read ports may hit the same register, and may hit the bypass, in the same cycle; each resolves independently.
- retired increments by 1 on posedge for every instruction whose value is not all zeros, including ST, branch, and r0-destination writes. It wraps from 0xFFFF to 0x0000.
- An instruction value of all zeros is a bubble (the MEM/WB reset value): no write, no count.

## Timing
- Reset (reset = 0, asynchronous): all registers are 0 and retired = 0 immediately, without waiting for a clock edge.
  - Read ports then return 0; the combinational outputs follow the inputs.
  - While reset is held low, no write or count occurs on clock edges.
  - Reset asserted mid-cycle discards any pending write; the first write after reset is released happens on the first posedge with reset = 1.
- Write latency: the value is in storage at posedge N.
  - Through the bypass, the value is visible on the read ports in the same cycle, before edge N.
  - Through storage, it is visible from edge N onward.
- retired reflects instructions retired up to and including the last posedge; latency is 1 cycle.
- No handshake: one instruction is consumed per cycle, and the stage never stalls.

## Test plan
- Reset: preload r3 = 0x12345, then drive reset low between clock edges -> rs1_data (addr 3) = 0 and retired = 0 before the next edge.
- ALU writeback with bypass: instruction = 0x36000 (opcode 0011, rd 3), alu_result = 0xABCDE, rs1_addr = 3 -> rs1_data = 0xABCDE in the same cycle. After the edge, with instruction = 0, rs1_data is still 0xABCDE and retired = 1.
- Load selection: instruction opcode 0001, rd 5, alu_result = 0x00010, mem_data = 0xFEDCB -> r5 = 0xFEDCB, and wb_data = 0xFEDCB during the cycle.
- r0 and non-writing classes:
  - ALU op with rd 0 and alu_result = 0xFFFFF -> wb_we = 0; r0 reads 0; retired increments.
  - ST with rd 2 -> r2 unchanged; retired increments.
  - NOP (instruction 0x00000) -> retired unchanged.
- Dual-port conflict: write r7 = 0x00777 while rs1_addr = rs2_addr = 7 -> both read ports = 0x00777. With rs2_addr = 6 instead, rs2_data returns the old r6.
- Counter wrap: issue 65536 ST instructions -> retired goes 0xFFFF -> 0x0000 with no glitch on other state.
